seq_shift_add_mult: RTL and testbench

- Sequential unsigned shift-and-add multiplier for the adder/multiplier datapath; consumes the half/full-adder ripple chain as its per-cycle W-bit adder.
- Takes two WIDTH-bit operands on a start pulse and iterates one multiplier bit per clock.
- Presents a 2*WIDTH-bit product with a busy/done handshake to the downstream consumer.

---
 rtl/seq_shift_add_mult.sv | 135 +++++++++++++
 tb/tb_seq_shift_add_mult.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_shift_add_mult.sv
// -----------------------------------------------------------------------------
// seq_shift_add_mult
//
// Sequential unsigned shift-and-add multiplier. A start pulse while idle
// captures the operands. The design then processes one multiplier bit per
// clock, using a WIDTH-bit adder whose carry-out is kept. The 2*WIDTH-bit
// product is presented together with a busy/done handshake.
//
// Optional build macro: SEQ_SHIFT_ADD_MULT_EARLY_EXIT_EN
//   When defined, an operation finishes as soon as the multiplier bits still
//   to be processed are all zero. In that final edge the work register is
//   shifted right by all remaining positions at once. The product is
//   identical to the full-length result.
//   When undefined, every operation takes exactly WIDTH RUN cycles.
//
// Ports:
//   clk    in   1        system clock, rising edge
//   rst_n  in   1        asynchronous active-low reset
//   start  in   1        request, sampled only while idle
//   a      in   WIDTH    multiplicand, captured on accepted start
//   b      in   WIDTH    multiplier, captured on accepted start
//   busy   out  1        high while iterating (RUN)
//   done   out  1        one-cycle pulse when p has just been updated
//   p      out  2*WIDTH  product; holds the last result until next completion
// -----------------------------------------------------------------------------
module seq_shift_add_mult #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] p
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [WIDTH-1:0]     r_mcand;
    // Upper half: partial product.
    // Lower half: multiplier bits not yet consumed.
    logic [2*WIDTH-1:0]   r_work;
    logic [CW-1:0]        r_count;

    logic [WIDTH:0]       w_sum;
    logic [2*WIDTH-1:0]   w_step;
    logic [2*WIDTH-1:0]   w_next;
    logic                 w_last;

    // One iteration: conditionally add the multiplicand into the upper half.
    // Then shift right by one, so the adder carry-out becomes the new MSB.
    always_comb begin
        w_sum  = {1'b0, r_work[2*WIDTH-1:WIDTH]}
               + (r_work[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
        w_step = {w_sum, r_work[WIDTH-1:1]};
    end

`ifdef SEQ_SHIFT_ADD_MULT_EARLY_EXIT_EN
    logic [WIDTH-1:0] w_rem_bits;
    logic             w_exit;
    logic [CW-1:0]    w_rem;

    // After r_count iterations, the unconsumed multiplier bits sit in
    // r_work[WIDTH-1-r_count:0]. Shifting left by r_count and truncating to
    // WIDTH bits isolates exactly those bits.
    // When they are all zero, no further adds can occur. The remaining
    // (WIDTH - r_count) shifts then collapse into a single shift.
    always_comb begin
        w_rem_bits = r_work[WIDTH-1:0] << r_count;
        w_exit     = (w_rem_bits == {WIDTH{1'b0}});
        w_rem      = CW'(WIDTH) - r_count;
        w_next     = w_exit ? (r_work >> w_rem) : w_step;
        w_last     = w_exit || (r_count == CW'(WIDTH - 1));
    end
`else
    always_comb begin
        w_next = w_step;
        w_last = (r_count == CW'(WIDTH - 1));
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_mcand <= '0;
            r_work  <= '0;
            r_count <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            p       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_mcand <= a;
                        r_work  <= {{WIDTH{1'b0}}, b};
                        r_count <= '0;
                        busy    <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_work  <= w_next;
                    r_count <= r_count + CW'(1);
                    if (w_last) begin
                        p       <= w_next;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_shift_add_mult.sv
module tb_seq_shift_add_mult;

    localparam int W = 4;

`ifdef SEQ_SHIFT_ADD_MULT_EARLY_EXIT_EN
    localparam int L_B1 = 2;    // b=1  -> h=0, N=2
    localparam int L_B0 = 1;    // b=0  -> N=1
    localparam int L_B3 = 3;    // b=3  -> h=1, N=3
    localparam int L_15_1_GAP = 4;
`else
    localparam int L_B1 = 4;
    localparam int L_B0 = 4;
    localparam int L_B3 = 4;
    localparam int L_15_1_GAP = 6;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           busy;
    logic           done;
    logic [2*W-1:0] p;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    seq_shift_add_mult #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .p     (p)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Timeline view: an accepted start at edge k leaves the DUT busy for N
    // cycles and pulses done after edge k+N. At that point p takes the product
    // a*b. The DUT becomes idle again after edge k+N+1.
    function automatic int calc_n(input logic [W-1:0] bv);
        int n;
        n = W;
`ifdef SEQ_SHIFT_ADD_MULT_EARLY_EXIT_EN
        if (bv == '0) n = 1;
        else begin
            int h;
            h = 0;
            for (int i = 0; i < W; i++) if (bv[i]) h = i;
            n = (h + 2 < W) ? h + 2 : W;
        end
`endif
        return n;
    endfunction

    bit  m_active = 1'b0;
    int  m_edge = 0;
    int  m_k = 0;
    int  m_n = 0;
    int  m_prod = 0;
    int  m_p = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 1'b0;
            m_p      = 0;
        end else begin
            m_edge = m_edge + 1;
            if (!m_active) begin
                if (start) begin
                    m_active = 1'b1;
                    m_k      = m_edge;
                    m_prod   = int'(a) * int'(b);
                    m_n      = calc_n(b);
                end
            end else if (m_edge == m_k + m_n) begin
                m_p = m_prod;
            end else if (m_edge == m_k + m_n + 1) begin
                m_active = 1'b0;
            end
        end
    end

    // Compare the DUT outputs against the model on every cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("model busy", 32'(busy), 32'(m_active && (m_edge < m_k + m_n)));
            chk("model done", 32'(done), 32'(m_active && (m_edge == m_k + m_n)));
            chk("model p", 32'(p), 32'(m_p));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic wait_done(input string nm, output int t, output int pv, output bit ok);
        ok = 1'b0;
        t  = 0;
        pv = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                t  = cyc;
                pv = int'(p);
                ok = 1'b1;
                return;
            end
        end
        total++;
        bad++;
        $display("FAIL %s timeout: got no done expected done within 40 cycles", nm);
    endtask

    task automatic op(input string nm, input int av, input int bv, input int ep, input int elat);
        int k, t, pv;
        bit ok;
        @(negedge clk);
        a = W'(av);
        b = W'(bv);
        start = 1'b1;
        @(posedge clk);
        #1 k = cyc;
        @(negedge clk);
        start = 1'b0;
        a = ~a;                     // operand changes after accept must not matter
        b = ~b;
        wait_done(nm, t, pv, ok);
        if (ok) begin
            chk({nm, " latency"}, 32'(t - k), 32'(elat));
            chk({nm, " p"}, 32'(pv), 32'(ep));
            $display("op %s: a=%0d b=%0d p=%0d latency=%0d", nm, av, bv, pv, t - k);
        end
    endtask

    initial begin
        int k, t0, t1, t2, p0, p1, p2;
        bit ok0, ok1, ok2;

        #12 rst_n = 1'b1;
        #1;
        chk("reset p", 32'(p), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);

        op("13x11", 13, 11, 143, 4);
        repeat (3) @(negedge clk);
        chk("p hold", 32'(p), 32'd143);

        op("15x15", 15, 15, 225, 4);
        op("0x9", 0, 9, 0, 4);
        op("9x0", 9, 0, 0, L_B0);
        op("9x1", 9, 1, 9, L_B1);
        op("9x8", 9, 8, 72, 4);

        // start held high: back-to-back operations
        @(negedge clk);
        a = 4'd3; b = 4'd5; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a = 4'd7; b = 4'd7;
        wait_done("b2b0", t0, p0, ok0);
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        a = 4'd15; b = 4'd1;
        wait_done("b2b1", t1, p1, ok1);
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_done("b2b2", t2, p2, ok2);
        if (ok0 && ok1 && ok2) begin
            chk("b2b p0", 32'(p0), 32'd15);
            chk("b2b p1", 32'(p1), 32'd49);
            chk("b2b p2", 32'(p2), 32'd15);
            chk("b2b gap01", 32'(t1 - t0), 32'd6);
            chk("b2b gap12", 32'(t2 - t1), 32'(L_15_1_GAP));
            $display("b2b: p=%0d,%0d,%0d done cycles %0d,%0d,%0d", p0, p1, p2, t0, t1, t2);
        end

        // start pulsed while busy is ignored
        @(negedge clk);
        a = 4'd6; b = 4'd6; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 4'd1; b = 4'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignore", t0, p0, ok0);
        if (ok0) chk("ignore p", 32'(p0), 32'd36);
        repeat (8) @(negedge clk);
        chk("ignore no rerun busy", 32'(busy), 32'd0);
        chk("ignore p kept", 32'(p), 32'd36);
        $display("ignore: p=%0d", p0);

        // asynchronous reset mid-run
        @(negedge clk);
        a = 4'd12; b = 4'd10; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst p", 32'(p), 32'd0);
        chk("async rst busy", 32'(busy), 32'd0);
        chk("async rst done", 32'(done), 32'd0);
        $display("async reset: p=%0d busy=%0d done=%0d", p, busy, done);
        @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("post rst no done p", 32'(p), 32'd0);
        op("2x3", 2, 3, 6, L_B3);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before 100000ns");
        $fatal(1, "watchdog");
    end

endmodule
